ppu_vmem: RTL and testbench

PPU_VMEM -- requirements
Module: ppu_vmem

---
 rtl/ppu_vmem_pkg.sv | 40 ++++
 rtl/ppu_ciram.sv | 35 +++
 rtl/ppu_vmem.sv | 119 +++++++++++
 tb/tb_ppu_vmem.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_vmem_pkg.sv
// ppu_vmem_pkg: shared constants and helpers for the PPU video-memory arbiter.
//   - Nametable mirroring encodings as driven on the mirror input.
//   - CIRAM region base and size.
//   - Controller state encoding.
//   - ciram_index(): folds a nametable address onto the 2 KB CIRAM.
package ppu_vmem_pkg;

    localparam logic [1:0] MirrorHorz    = 2'd0;
    localparam logic [1:0] MirrorVert    = 2'd1;
    localparam logic [1:0] MirrorSingleA = 2'd2;
    localparam logic [1:0] MirrorSingleB = 2'd3;

    // Everything at or above this address lands in CIRAM, palette range included.
    localparam logic [13:0] CiramBase  = 14'h2000;
    localparam int unsigned CiramDepth = 2048;
    localparam int unsigned CiramAw    = 11;

    typedef enum logic [2:0] {
        StIdle,
        StCiram,
        StChrWait,
        StAck,
        StHold
    } state_e;

    // Only addr[11:0] matters: 0x3000-0x3FFF aliases 0x2000-0x2FFF.
    function automatic logic [CiramAw-1:0] ciram_index(input logic [11:0] addr,
                                                       input logic [1:0]  mirror);
        logic a10;
        a10 = 1'b0;
        unique case (mirror)
            MirrorHorz:    a10 = addr[11];
            MirrorVert:    a10 = addr[10];
            MirrorSingleA: a10 = 1'b0;
            MirrorSingleB: a10 = 1'b1;
        endcase
        return {a10, addr[9:0]};
    endfunction

endpackage

// File: rtl/ppu_ciram.sv
// ppu_ciram: 2 KB console-internal video RAM.
//   Single-port synchronous RAM, one-cycle registered read.
//   clk_i    clock
//   en_i     access enable for this cycle
//   we_i     1 = write wdata_i, 0 = read into rdata_o
//   addr_i   11-bit word address
//   wdata_i  write data
//   rdata_o  read data, valid the cycle after a read access, held otherwise
module ppu_ciram
    import ppu_vmem_pkg::*;
(
    input  logic               clk_i,
    input  logic               en_i,
    input  logic               we_i,
    input  logic [CiramAw-1:0] addr_i,
    input  logic [7:0]         wdata_i,
    output logic [7:0]         rdata_o
);

    logic [7:0] mem_q [CiramDepth];
    logic [7:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ppu_vmem.sv
// ppu_vmem: PPU video-memory controller.
//   Routes PPU accesses either to internal CIRAM (0x2000-0x3FFF, mirrored per the
//   cartridge's nametable layout) or to the cartridge CHR port (0x0000-0x1FFF).
//   clk, reset                     clock, synchronous active-high reset
//   vmemaddr/wdata/wr/req          PPU request (level, held until vmemack)
//   vmemack, vmemrdata             one-cycle completion pulse, read data (held)
//   mirror                         nametable mirroring mode, sampled at request
//   chraddr/wdata/wr/req           cartridge CHR request (level, held until chrack)
//   chrack, chrrdata               cartridge completion pulse with read data
//   CHRWRITE                       1 forwards pattern-table writes to the cart
module ppu_vmem
    import ppu_vmem_pkg::*;
#(
    parameter bit CHRWRITE = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [13:0] vmemaddr,
    input  logic [7:0]  vmemwdata,
    input  logic        vmemwr,
    input  logic        vmemreq,
    output logic        vmemack,
    output logic [7:0]  vmemrdata,
    input  logic [1:0]  mirror,
    output logic [12:0] chraddr,
    output logic [7:0]  chrwdata,
    output logic        chrwr,
    output logic        chrreq,
    input  logic        chrack,
    input  logic [7:0]  chrrdata
);

    state_e             state_q, state_d;
    logic [12:0]        addr_q;
    logic [7:0]         wdata_q;
    logic               wr_q;
    logic               ciram_q;
    logic [CiramAw-1:0] idx_q;
    logic [7:0]         rdata_q;

    logic               req_is_ciram;
    logic               chr_drop;
    logic               take_req;
    logic               ram_en;
    logic               ram_rd_done;
    logic [7:0]         ram_rdata;

    assign req_is_ciram = (vmemaddr >= CiramBase);
    // Pattern-table writes on CHR-ROM carts are swallowed. They still pass through
    // StCiram (with the RAM idle) so the ack lands with the same latency.
    assign chr_drop     = !req_is_ciram && vmemwr && !CHRWRITE;
    assign take_req     = (state_q == StIdle) && vmemreq;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (vmemreq) begin
                    state_d = (req_is_ciram || chr_drop) ? StCiram : StChrWait;
                end
            end
            StCiram:   state_d = StAck;
            StChrWait: if (chrack) state_d = StAck;
            StAck:     state_d = StHold;
            // Absorbs the requester's registered req drop so it is not seen as new.
            StHold:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Gating with reset keeps a write from landing on the very edge that aborts it.
    assign ram_en      = (state_q == StCiram) && ciram_q && !reset;
    assign ram_rd_done = (state_q == StAck) && ciram_q && !wr_q;

    ppu_ciram u_ciram (
        .clk_i   (clk),
        .en_i    (ram_en),
        .we_i    (wr_q),
        .addr_i  (idx_q),
        .wdata_i (wdata_q),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            ciram_q <= 1'b0;
            idx_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (take_req) begin
                addr_q  <= vmemaddr[12:0];
                wdata_q <= vmemwdata;
                wr_q    <= vmemwr;
                ciram_q <= req_is_ciram;
                idx_q   <= ciram_index(vmemaddr[11:0], mirror);
            end
            if ((state_q == StChrWait) && chrack && !wr_q) begin
                rdata_q <= chrrdata;
            end
            if (ram_rd_done) begin
                rdata_q <= ram_rdata;
            end
        end
    end

    assign vmemack   = (state_q == StAck);
    // CIRAM data only exists after the RAM edge, so bypass it during the ack cycle.
    assign vmemrdata = ram_rd_done ? ram_rdata : rdata_q;
    assign chrreq    = (state_q == StChrWait);
    assign chrwr     = chrreq && wr_q;
    assign chraddr   = addr_q;
    assign chrwdata  = wdata_q;

endmodule

// File: tb/tb_ppu_vmem.sv
// Bench for ppu_vmem: one instance per CHRWRITE setting, cartridge stubs, and a
// queue-based scoreboard fed by the stimulus and drained by a negedge monitor.
module tb_ppu_vmem;

    typedef struct {
        bit       rd;
        bit [7:0] data;
        bit       chk;
        bit       is_chr;
        int       cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       rst;
    logic [1:0][13:0] vaddr;
    logic [1:0][7:0]  vwd;
    logic [1:0]       vwr;
    logic [1:0]       vreq;
    logic [1:0]       vack;
    logic [1:0][7:0]  vrd;
    logic [1:0][1:0]  mir;
    logic [1:0][12:0] caddr;
    logic [1:0][7:0]  cwd;
    logic [1:0]       cwr;
    logic [1:0]       creq;
    logic [1:0]       cack = '0;
    logic [1:0][7:0]  crd  = '0;

    ppu_vmem #(.CHRWRITE(1'b0)) dut0 (
        .clk(clk), .reset(rst[0]), .vmemaddr(vaddr[0]), .vmemwdata(vwd[0]),
        .vmemwr(vwr[0]), .vmemreq(vreq[0]), .vmemack(vack[0]), .vmemrdata(vrd[0]),
        .mirror(mir[0]), .chraddr(caddr[0]), .chrwdata(cwd[0]), .chrwr(cwr[0]),
        .chrreq(creq[0]), .chrack(cack[0]), .chrrdata(crd[0])
    );

    ppu_vmem #(.CHRWRITE(1'b1)) dut1 (
        .clk(clk), .reset(rst[1]), .vmemaddr(vaddr[1]), .vmemwdata(vwd[1]),
        .vmemwr(vwr[1]), .vmemreq(vreq[1]), .vmemack(vack[1]), .vmemrdata(vrd[1]),
        .mirror(mir[1]), .chraddr(caddr[1]), .chrwdata(cwd[1]), .chrwr(cwr[1]),
        .chrreq(creq[1]), .chrack(cack[1]), .chrrdata(crd[1])
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t sb0[$];
    exp_t sb1[$];

    // Driver-owned configuration read by the stubs.
    bit [1:0]        stub_en;
    bit [1:0]        expect_chr;
    logic [1:0][12:0] exp_caddr;
    bit [1:0]        exp_cwr;
    logic [1:0][7:0] exp_cwd;
    int              stub_dly[2];
    int              late_req[2];
    // Model state, driver-owned.
    bit [7:0]        cmem[2][2048];
    bit              cknown[2][2048];
    bit [7:0]        mchr[2][8192];
    bit              mchr_wr[2][8192];
    bit [7:0]        rd_model[2];
    bit              rd_known[2];
    // Stub/monitor-owned state.
    bit [7:0]        cart_mem[2][8192];
    bit              cart_wr[2][8192];
    int              hi_cnt[2];
    int              chrack_cyc[2];
    int              late_done[2];
    int              ack_cnt[2];

    task automatic chk(input string name, input int d, input logic [31:0] act,
                       input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h (cycle %0d)", name, d, act,
                     want, cyc);
        end
    endtask

    // Factory contents of the cartridge CHR memory.
    function automatic bit [7:0] cart_init(input int a);
        return 8'((a * 37 + 11) ^ (a >> 5));
    endfunction

    // Nametable n (0..3) lives on physical 1 KB page chosen by the mirroring mode.
    function automatic int ciram_idx(input logic [13:0] a, input logic [1:0] m);
        int nt, page;
        nt = int'(a[11:10]);
        case (m)
            2'd0:    page = nt / 2;
            2'd1:    page = nt % 2;
            2'd2:    page = 0;
            default: page = 1;
        endcase
        return page * 1024 + int'(a[9:0]);
    endfunction

    task automatic mon(input int d);
        exp_t e;
        if (vack[d]) begin
            ack_cnt[d]++;
            if ((d == 0 && sb0.size() == 0) || (d == 1 && sb1.size() == 0)) begin
                chk("unexpected_ack", d, 32'(vack[d]), 32'd0);
            end else begin
                if (d == 0) e = sb0.pop_front();
                else        e = sb1.pop_front();
                chk("ack_cycle", d, 32'(cyc), 32'(e.is_chr ? chrack_cyc[d] + 1 : e.cyc));
                if (e.chk) chk(e.rd ? "read_data" : "write_keeps_rdata", d, 32'(vrd[d]),
                               32'(e.data));
            end
        end
    endtask

    task automatic stub(input int d);
        if (!stub_en[d]) begin
            if (late_done[d] != late_req[d]) begin
                cack[d] = 1'b1;
                crd[d]  = 8'hEE;
                late_done[d]++;
            end else begin
                cack[d] = 1'b0;
            end
        end else if (cack[d]) begin
            cack[d] = 1'b0;
            chk("chrreq_drop", d, 32'(creq[d]), 32'd0);
            hi_cnt[d] = 0;
        end else if (creq[d]) begin
            hi_cnt[d]++;
            if (hi_cnt[d] == 1) begin
                chk("chrreq_expected", d, 32'(creq[d]), 32'(expect_chr[d]));
                chk("chraddr", d, 32'(caddr[d]), 32'(exp_caddr[d]));
                chk("chrwr", d, 32'(cwr[d]), 32'(exp_cwr[d]));
                if (exp_cwr[d]) chk("chrwdata", d, 32'(cwd[d]), 32'(exp_cwd[d]));
            end
            if (hi_cnt[d] >= stub_dly[d]) begin
                cack[d] = 1'b1;
                crd[d]  = cart_wr[d][caddr[d]] ? cart_mem[d][caddr[d]]
                                               : cart_init(int'(caddr[d]));
                if (cwr[d]) begin
                    cart_mem[d][caddr[d]] = cwd[d];
                    cart_wr[d][caddr[d]]  = 1'b1;
                end
                chrack_cyc[d] = cyc;
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
        stub(0);
        stub(1);
    end

    // Call at posedge+1 with the DUT idle (lead=0) or in its hold cycle (lead=1).
    task automatic issue(input int d, input logic [13:0] a, input bit w, input logic [7:0] wd,
                         input logic [1:0] m, input int dly, input bit hold_after,
                         input int lead);
        exp_t e;
        bit   ciram, dropped;
        int   idx, base, n;
        ciram    = (a >= 14'h2000);
        dropped  = !ciram && w && (d == 0);
        e.rd     = !w;
        e.is_chr = !ciram && !dropped;
        e.cyc    = cyc + 2 + lead;
        e.chk    = 1'b0;
        e.data   = 8'h00;
        if (ciram) begin
            idx = ciram_idx(a, m);
            if (w) begin
                cmem[d][idx]   = wd;
                cknown[d][idx] = 1'b1;
            end else begin
                e.data = cmem[d][idx];
                e.chk  = cknown[d][idx];
            end
        end else if (!w) begin
            e.data = mchr_wr[d][a[12:0]] ? mchr[d][a[12:0]] : cart_init(int'(a[12:0]));
            e.chk  = 1'b1;
        end else if (!dropped) begin
            mchr[d][a[12:0]]    = wd;
            mchr_wr[d][a[12:0]] = 1'b1;
        end
        if (w) begin
            e.data = rd_model[d];
            e.chk  = rd_known[d];
        end else begin
            rd_model[d] = e.data;
            rd_known[d] = e.chk;
        end
        expect_chr[d] = e.is_chr;
        exp_caddr[d]  = a[12:0];
        exp_cwr[d]    = w;
        exp_cwd[d]    = wd;
        stub_dly[d]   = dly;
        vaddr[d] = a;
        vwr[d]   = w;
        vwd[d]   = wd;
        mir[d]   = m;
        vreq[d]  = 1'b1;
        if (d == 0) sb0.push_back(e);
        else        sb1.push_back(e);
        base = ack_cnt[d];
        n = 0;
        while (ack_cnt[d] == base && n < 80) begin
            @(posedge clk);
            n++;
        end
        if (ack_cnt[d] == base) chk("ack_timeout", d, 32'(ack_cnt[d] - base), 32'd1);
        #1;
        if (!hold_after) begin
            vreq[d] = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset_outputs(input int d);
        chk("rst_vmemack", d, 32'(vack[d]), 32'd0);
        chk("rst_vmemrdata", d, 32'(vrd[d]), 32'd0);
        chk("rst_chrreq", d, 32'(creq[d]), 32'd0);
        chk("rst_chrwr", d, 32'(cwr[d]), 32'd0);
        chk("rst_chraddr", d, 32'(caddr[d]), 32'd0);
        chk("rst_chrwdata", d, 32'(cwd[d]), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [13:0] a;
        rst     = 2'b11;
        vaddr   = '0;
        vwd     = '0;
        vwr     = '0;
        vreq    = '0;
        mir     = '0;
        stub_en = 2'b11;
        for (int d = 0; d < 2; d++) begin
            rd_model[d] = 8'h00;
            rd_known[d] = 1'b1;
            stub_dly[d] = 1;
            late_req[d] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs(0);
        check_reset_outputs(1);
        rst = 2'b00;

        // Vertical mirroring: 0x2400 and 0x2C00 share a page, 0x2000 does not.
        issue(0, 14'h2000, 1, 8'h33, 2'd1, 1, 0, 0);
        issue(0, 14'h2400, 1, 8'h55, 2'd1, 1, 0, 0);
        issue(0, 14'h2C00, 0, 8'h00, 2'd1, 1, 0, 0);
        issue(0, 14'h2000, 0, 8'h00, 2'd1, 1, 0, 0);
        // Horizontal mirroring, including the 0x3xxx aliases.
        issue(0, 14'h2000, 1, 8'hA1, 2'd0, 1, 0, 0);
        issue(0, 14'h2800, 1, 8'h5C, 2'd0, 1, 0, 0);
        issue(0, 14'h2B00, 1, 8'h6B, 2'd0, 1, 0, 0);
        issue(0, 14'h2400, 0, 8'h00, 2'd0, 1, 0, 0);
        issue(0, 14'h2800, 0, 8'h00, 2'd0, 1, 0, 0);
        issue(0, 14'h3000, 0, 8'h00, 2'd0, 1, 0, 0);
        issue(0, 14'h3F00, 0, 8'h00, 2'd0, 1, 0, 0);
        // Single-screen modes.
        issue(0, 14'h2C05, 1, 8'h17, 2'd2, 1, 0, 0);
        issue(0, 14'h2005, 0, 8'h00, 2'd2, 1, 0, 0);
        issue(0, 14'h2405, 1, 8'h28, 2'd3, 1, 0, 0);
        issue(0, 14'h2805, 0, 8'h00, 2'd3, 1, 0, 0);
        // CHR read with a slow cart, then a dropped CHR write that must not stick.
        issue(0, 14'h1234, 0, 8'h00, 2'd0, 5, 0, 0);
        issue(0, 14'h0010, 1, 8'h9C, 2'd0, 1, 0, 0);
        issue(0, 14'h0010, 0, 8'h00, 2'd0, 2, 0, 0);
        // Request held high across three CIRAM reads.
        issue(0, 14'h2400, 0, 8'h00, 2'd1, 1, 1, 0);
        issue(0, 14'h2C00, 0, 8'h00, 2'd1, 1, 1, 1);
        issue(0, 14'h2000, 0, 8'h00, 2'd1, 1, 0, 1);
        repeat (4) @(posedge clk);
        #1;

        // CHR-RAM cart: writes reach the cart.
        issue(1, 14'h0010, 1, 8'h9C, 2'd0, 2, 0, 0);
        issue(1, 14'h0010, 0, 8'h00, 2'd0, 1, 0, 0);
        issue(1, 14'h1234, 1, 8'h7E, 2'd0, 3, 0, 0);
        issue(1, 14'h1234, 0, 8'h00, 2'd0, 5, 0, 0);

        // Reset in the middle of a CHR wait, followed by a stray chrack.
        stub_en[1] = 1'b0;
        vaddr[1] = 14'h0ABC;
        vwr[1]   = 1'b0;
        vreq[1]  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("chrreq_before_reset", 1, 32'(creq[1]), 32'd1);
        chk("chraddr_before_reset", 1, 32'(caddr[1]), 32'h0ABC);
        rst[1]  = 1'b1;
        vreq[1] = 1'b0;
        @(posedge clk);
        #1;
        rst[1] = 1'b0;
        check_reset_outputs(1);
        late_req[1]++;
        repeat (4) @(posedge clk);
        #1;
        chk("late_chrack_rdata", 1, 32'(vrd[1]), 32'd0);
        chk("late_chrack_chrreq", 1, 32'(creq[1]), 32'd0);
        rd_model[1] = 8'h00;
        rd_known[1] = 1'b1;
        stub_en[1]  = 1'b1;
        issue(1, 14'h0010, 0, 8'h00, 2'd0, 3, 0, 0);

        // Randomised traffic on both flavours.
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 150; i++) begin
                if ($urandom_range(0, 2) == 0) begin
                    a = {1'b0, 13'($urandom)};
                end else begin
                    a = {1'b1, 3'($urandom), 10'($urandom_range(0, 15))};
                end
                issue(d, a, 1'($urandom), 8'($urandom), 2'($urandom), $urandom_range(1, 4),
                      0, 0);
            end
        end

        repeat (4) @(posedge clk);
        #1;
        chk("sb0_drained", 0, 32'(sb0.size()), 32'd0);
        chk("sb1_drained", 1, 32'(sb1.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
